// File: rtl/mem_ctrl_if.sv
// Bus bundle between mem_ctrl, its two requesters (IFetch, LSB) and the byte-wide RAM/IO port.
// The controller uses the slave modport; the requester/RAM side uses master.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 3
);
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;
  logic              IF_S;
  logic [ADDR_W-1:0] IF_pc;
  logic              LSB_S;
  logic              LSB_op;
  logic [ADDR_W-1:0] LSB_pc;
  logic [LEN_W-1:0]  LSB_len;
  logic [DATA_W-1:0] LSB_value;
  logic              Mem_success;
  logic              Mem_type;
  logic [DATA_W-1:0] Mem_value;

  modport slave (
    input  mem_din, io_buffer_full, IF_S, IF_pc, LSB_S, LSB_op, LSB_pc, LSB_len, LSB_value,
    output mem_dout, mem_a, mem_wr, Mem_success, Mem_type, Mem_value
  );

  modport master (
    output mem_din, io_buffer_full, IF_S, IF_pc, LSB_S, LSB_op, LSB_pc, LSB_len, LSB_value,
    input  mem_dout, mem_a, mem_wr, Mem_success, Mem_type, Mem_value
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: arbitrates LSB over IFetch, issues 1/2/4 byte accesses.
// Optional MEMCTRL_IO_STALL_EN holds IO-space store bytes while the IO write buffer is full.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      clr,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            r_state, w_state_d;
  logic              r_owner, w_owner_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d, r_mem_a, w_mem_a_d;
  logic [2:0]        r_len, w_len_d, r_cnt, w_cnt_d;
  logic [DATA_W-1:0] r_data, w_data_d, r_buf, w_buf_d, r_value, w_value_d;
  logic [7:0]        r_dout, w_dout_d, r_hold, w_hold_d;
  logic              r_held, w_held_d, r_wr, w_wr_d;
  logic              r_success, w_success_d, r_type, w_type_d;

  logic [2:0]        w_lsb_len, w_cnt_inc;
  logic [1:0]        w_rd_idx, w_wr_idx;
  logic [7:0]        w_rd_byte;
  logic [DATA_W-1:0] w_buf_upd;
  logic [ADDR_W-1:0] w_req_addr, w_next_addr;
  logic              w_io_block;

  always_comb begin
    if (bus.LSB_len == LEN_W'(1))      w_lsb_len = 3'd1;
    else if (bus.LSB_len == LEN_W'(2)) w_lsb_len = 3'd2;
    else                               w_lsb_len = 3'd4;
  end

  assign w_cnt_inc   = r_cnt + 3'd1;
  assign w_rd_idx    = 2'(r_cnt - 3'd1);
  assign w_wr_idx    = w_cnt_inc[1:0];
  assign w_next_addr = r_addr + ADDR_W'(w_cnt_inc);
  assign w_req_addr  = bus.LSB_S ? bus.LSB_pc : bus.IF_pc;
  // A byte caught while frozen stands in for mem_din, which by then reflects the held address.
  assign w_rd_byte   = r_held ? r_hold : bus.mem_din;

  always_comb begin
    w_buf_upd = r_buf;
    w_buf_upd[{w_rd_idx, 3'b000} +: 8] = w_rd_byte;
  end

`ifdef MEMCTRL_IO_STALL_EN
  assign w_io_block = (r_state == StWrite) && (r_mem_a[17:16] == 2'b11) && bus.io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = bus.io_buffer_full;
  assign w_io_block  = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_owner_d   = r_owner;
    w_addr_d    = r_addr;
    w_mem_a_d   = r_mem_a;
    w_len_d     = r_len;
    w_cnt_d     = r_cnt;
    w_data_d    = r_data;
    w_buf_d     = r_buf;
    w_value_d   = r_value;
    w_dout_d    = r_dout;
    w_hold_d    = r_hold;
    w_held_d    = r_held;
    w_wr_d      = r_wr;
    w_success_d = r_success;
    w_type_d    = r_type;
    if (!rdy) begin
      if (r_state == StRead && !r_held && r_cnt != 3'd0) begin
        w_hold_d = bus.mem_din;
        w_held_d = 1'b1;
      end
    end else begin
      w_success_d = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!clr && (bus.LSB_S || bus.IF_S)) begin
            w_owner_d = bus.LSB_S;
            w_addr_d  = w_req_addr;
            w_mem_a_d = w_req_addr;
            w_len_d   = bus.LSB_S ? w_lsb_len : 3'd4;
            w_data_d  = bus.LSB_value;
            w_buf_d   = '0;
            w_cnt_d   = 3'd0;
            w_held_d  = 1'b0;
            if (bus.LSB_S && bus.LSB_op) begin
              w_state_d = StWrite;
              w_dout_d  = bus.LSB_value[7:0];
              w_wr_d    = 1'b1;
            end else begin
              w_state_d = StRead;
            end
          end
        end
        StRead: begin
          w_held_d = 1'b0;
          if (clr) begin
            w_state_d = StIdle;
          end else if (r_cnt == r_len) begin
            w_state_d   = StDone;
            w_success_d = 1'b1;
            w_type_d    = r_owner;
            w_value_d   = w_buf_upd;
          end else begin
            if (r_cnt != 3'd0) w_buf_d = w_buf_upd;
            w_cnt_d = w_cnt_inc;
            if (w_cnt_inc < r_len) w_mem_a_d = w_next_addr;
          end
        end
        StWrite: begin
          // Stores are committed, so clr never cuts one short.
          if (!w_io_block) begin
            if (w_cnt_inc < r_len) begin
              w_cnt_d   = w_cnt_inc;
              w_mem_a_d = w_next_addr;
              w_dout_d  = r_data[{w_wr_idx, 3'b000} +: 8];
            end else begin
              w_wr_d      = 1'b0;
              w_state_d   = StDone;
              w_success_d = 1'b1;
              w_type_d    = r_owner;
              w_value_d   = '0;
            end
          end
        end
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_owner   <= 1'b0;
      r_addr    <= '0;
      r_mem_a   <= '0;
      r_len     <= 3'd0;
      r_cnt     <= 3'd0;
      r_data    <= '0;
      r_buf     <= '0;
      r_value   <= '0;
      r_dout    <= 8'h00;
      r_hold    <= 8'h00;
      r_held    <= 1'b0;
      r_wr      <= 1'b0;
      r_success <= 1'b0;
      r_type    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_owner   <= w_owner_d;
      r_addr    <= w_addr_d;
      r_mem_a   <= w_mem_a_d;
      r_len     <= w_len_d;
      r_cnt     <= w_cnt_d;
      r_data    <= w_data_d;
      r_buf     <= w_buf_d;
      r_value   <= w_value_d;
      r_dout    <= w_dout_d;
      r_hold    <= w_hold_d;
      r_held    <= w_held_d;
      r_wr      <= w_wr_d;
      r_success <= w_success_d;
      r_type    <= w_type_d;
    end
  end

  // Freeze and IO stall gate the strobes so a held byte or pulse reissues once released.
  assign bus.mem_wr      = r_wr & rdy & ~w_io_block;
  assign bus.Mem_success = r_success & rdy;
  assign bus.mem_a       = r_mem_a;
  assign bus.mem_dout    = r_dout;
  assign bus.Mem_type    = r_type;
  assign bus.Mem_value   = r_value;
endmodule
